multicycle_core: RTL

MULTICYCLE_CORE -- requirements
Module: multicycle_core

---
 rtl/multicycle_core.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/multicycle_core.sv
// Multicycle load/store core: FETCH/DECODE/EXEC/MEM/WB sequencer driving
// request/acknowledge instruction and data ports, with debug observation outputs.
module multicycle_core #(
    parameter int DATA_W = 32,
    parameter int NREGS  = 32,
    parameter int PC_W   = 16
) (
    input  logic              clock,
    input  logic              reset,
    output logic              imem_req,
    output logic [PC_W-1:0]   imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [DATA_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic              dmem_ack,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic [PC_W-1:0]   pc,
    output logic [2:0]        state,
    output logic [1:0]        flags,
    output logic [31:0]       retired,
    output logic [DATA_W-1:0] wb_value
);
    localparam int RW = $clog2(NREGS);
    localparam logic [RW-1:0] LR = RW'(NREGS - 1);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        TRAP   = 3'd7
    } state_t;

    state_t            st;
    logic [31:0]       instr;
    logic [DATA_W-1:0] regs [NREGS];
    logic [DATA_W-1:0] result;

    logic [1:0]        itype;
    logic [2:0]        cond;
    logic              imm_sel;
    logic [1:0]        op;
    logic              sl;
    logic [RW-1:0]     rd, rh, ro;
    logic [DATA_W-1:0] opa, opb, alu_out, mem_addr;
    logic              cond_ok;
    logic [PC_W-1:0]   pc_inc, target;

    assign itype   = instr[31:30];
    assign cond    = instr[29:27];
    assign imm_sel = instr[26];
    assign op      = instr[25:24];
    assign sl      = instr[23];
    assign rd      = instr[18 +: RW];
    assign rh      = instr[13 +: RW];
    assign ro      = instr[8 +: RW];

    assign imem_addr = pc;
    assign state     = st;

    // NOTE: every always_comb output gets a value on every path, so no latch can be inferred.
    always_comb begin
        opa      = regs[rh];
        opb      = imm_sel ? DATA_W'(instr[11:0]) : regs[ro];
        mem_addr = opa + opb;
        unique case (op)
            2'b00:   alu_out = opa + opb;
            2'b01:   alu_out = opa - opb;
            2'b10:   alu_out = opa & opb;
            default: alu_out = opa | opb;
        endcase
        case (cond)
            3'b000:  cond_ok = 1'b1;
            3'b001:  cond_ok = flags[0];
            3'b010:  cond_ok = !flags[0];
            3'b011:  cond_ok = flags[1];
            3'b100:  cond_ok = !flags[1];
            default: cond_ok = 1'b0;
        endcase
        pc_inc = pc + PC_W'(1);
        // Offset is sign-extended from 22 bits before the sum is truncated to PC_W.
        target = PC_W'(32'(pc_inc) + 32'($signed(instr[21:0])));
    end

    // NOTE: sequential state uses non-blocking assignments only, so every read in this block sees pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            st         <= FETCH;
            pc         <= '0;
            instr      <= '0;
            result     <= '0;
            flags      <= '0;
            retired    <= '0;
            wb_value   <= '0;
            imem_req   <= 1'b0;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
            // NOTE: the register file must read zero after reset, so it is flops with async clear, not a RAM macro.
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else begin
            case (st)
                FETCH: begin
                    // Request is raised on the first edge in FETCH; an ack only counts while it is high.
                    if (imem_req && imem_ack) begin
                        instr    <= imem_rdata;
                        imem_req <= 1'b0;
                        st       <= DECODE;
                    end else begin
                        imem_req <= 1'b1;
                    end
                end
                DECODE: begin
                    if (itype == 2'b11) begin
                        st <= TRAP;
                    end else if (!cond_ok) begin
                        pc       <= pc_inc;
                        retired  <= retired + 32'd1;
                        imem_req <= 1'b1;
                        st       <= FETCH;
                    end else begin
                        st <= EXEC;
                    end
                end
                EXEC: begin
                    case (itype)
                        2'b00: begin
                            result <= alu_out;
                            st     <= WB;
                        end
                        2'b01: begin
                            dmem_req   <= 1'b1;
                            dmem_we    <= !sl;
                            dmem_addr  <= mem_addr;
                            dmem_wdata <= regs[rd];
                            st         <= MEM;
                        end
                        default: begin
                            if (sl) begin
                                regs[LR] <= DATA_W'(pc_inc);
                                wb_value <= DATA_W'(pc_inc);
                            end
                            pc       <= target;
                            retired  <= retired + 32'd1;
                            imem_req <= 1'b1;
                            st       <= FETCH;
                        end
                    endcase
                end
                MEM: begin
                    if (dmem_ack) begin
                        dmem_req <= 1'b0;
                        dmem_we  <= 1'b0;
                        if (sl) begin
                            result <= dmem_rdata;
                            st     <= WB;
                        end else begin
                            pc       <= pc_inc;
                            retired  <= retired + 32'd1;
                            imem_req <= 1'b1;
                            st       <= FETCH;
                        end
                    end
                end
                WB: begin
                    regs[rd] <= result;
                    wb_value <= result;
                    if (itype == 2'b00 && sl) flags <= {result[DATA_W-1], result == '0};
                    pc       <= pc_inc;
                    retired  <= retired + 32'd1;
                    imem_req <= 1'b1;
                    st       <= FETCH;
                end
                default: begin
                    imem_req <= 1'b0;
                    dmem_req <= 1'b0;
                    dmem_we  <= 1'b0;
                end
            endcase
        end
    end
endmodule
